adc_frame_capture: RTL and testbench
====================================

Name: adc_frame_capture

Overview:
- Sits between the ADC sampler (8-bit samples) and the LCD display RAM write port; the LCD control stage reads the RAM to draw a scope trace.
- Decimates the incoming sample stream and waits for a rising-edge level trigger, with an auto-trigger timeout.
- Writes one frame of DEPTH samples into the RAM, then holds until the display side acknowledges.

Parameters:
- DEPTH, 128, samples per frame (one per LCD column); power of two, at most 1024.
- BASE_ADDR, 0, first RAM address of the frame.
- AUTO_TIMEOUT, 1024, decimated samples to wait in ARMED before forcing a trigger.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; 1 = acquire frames continuously, 0 = stop/abort.
- sample_en  input  1  one-cycle strobe; adc_data is valid this cycle.
- adc_data  input  8  unsigned ADC sample.
- trig_level  input  8  trigger threshold, sampled live.
- decim  input  4  accept one of every decim+1 strobes (0 = every strobe).
- frame_ack  input  1  one-cycle pulse from the display side; frame has been consumed.
- ram_wr_data  output  8  sample written to RAM.
- ram_wr_addr  output  10  RAM write address.
- ram_wren  output  1  one-cycle write enable.
- frame_done  output  1  level; a complete frame is in RAM.
- auto_trig  output  1  level; the current or last frame was started by timeout.
- state  output  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=HOLD.

Behaviour:
- Reset (asynchronous, rst_n=0) clears all registers and outputs:
  - state=IDLE.
  - ram_wr_data=0, ram_wr_addr=BASE_ADDR, ram_wren=0, frame_done=0, auto_trig=0.
  - Decimation counter, timeout counter, sample index, prev_valid: all 0.
- Decimation:
  - The counter runs only in ARMED and CAPTURE and increments on each sample_en.
  - A strobe is "accepted" when counter==decim; the counter then returns to 0.
  - The counter clears on every state change.
- IDLE -> ARMED when run=1. On entry, prev_valid=0 and the timeout counter is 0.
- ARMED, on each accepted sample:
  - If prev_valid and prev<trig_level and adc_data>=trig_level, the trigger is real: auto_trig=0.
  - Else, if the timeout counter reaches AUTO_TIMEOUT-1, the trigger is forced: auto_trig=1.
  - Else, increment the timeout counter, set prev=adc_data and prev_valid=1.
  - On either trigger: go to CAPTURE. The triggering sample is written as index 0.
- CAPTURE:
  - Each accepted sample is written at ram_wr_addr=BASE_ADDR+index, with ram_wren high for exactly one cycle.
  - The write is registered: ram_wren asserts the cycle after the accepting sample_en (latency 1).
  - After the write at index DEPTH-1, go to HOLD and assert frame_done in the same cycle as that final ram_wren.
- HOLD:
  - Samples are ignored and frame_done stays 1.
  - On frame_ack: frame_done=0, then go to ARMED if run=1, else IDLE.
- Address and width rules:
  - Index width is log2(DEPTH). The address is BASE_ADDR+index truncated to 10 bits and never exceeds BASE_ADDR+DEPTH-1.
  - The sample index wraps only by leaving CAPTURE.
- Boundary conditions:
  - run=0 in ARMED or CAPTURE aborts to IDLE next cycle. No further writes; frame_done stays 0; a partial frame remains in RAM.
  - run=0 in HOLD: stay in HOLD until frame_ack.
  - frame_ack outside HOLD is ignored.
  - A sample_en arriving in the same cycle as an abort is not written.
  - decim changed mid-frame takes effect on the next comparison; the counter never exceeds 15.
  - trig_level equal to the sample counts as a crossing; a flat input never triggers except by timeout.
  - Reset mid-CAPTURE: ram_wren drops immediately (asynchronously).

Test Plan:
- Ramp 0..255 on every strobe, trig_level=100, decim=0, run=1 -> first write has data=100 at addr 0; 128 consecutive writes with data 100..227; frame_done rises with the write at addr 127; state=3.
- Constant input 50, trig_level=200, decim=0 -> after 1024 accepted samples, auto_trig=1 and capture starts; 128 writes of 50.
- decim=3 with the ramp -> writes occur on every 4th strobe; written data steps by 4.
- In HOLD, pulse frame_ack with run=1 -> frame_done=0 next cycle and state=1; a second frame captures on the next crossing. Repeat with run=0 -> state=0.
- Drop run at write index 40 -> no write after index 40; state=0; frame_done stays 0.
- Assert rst_n=0 mid-capture -> all outputs return to reset values asynchronously; after release with run=1, the next frame starts at addr BASE_ADDR.

Source files
------------

// File: rtl/adc_frame_capture.sv
// Captures one decimated, level-triggered frame of ADC samples into the LCD
// display RAM, then holds it until the display side acknowledges.
module adc_frame_capture #(
  parameter int DEPTH        = 128,
  parameter int BASE_ADDR    = 0,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       sample_en,
  input  logic [7:0] adc_data,
  input  logic [7:0] trig_level,
  input  logic [3:0] decim,
  input  logic       frame_ack,
  output logic [7:0] ram_wr_data,
  output logic [9:0] ram_wr_addr,
  output logic       ram_wren,
  output logic       frame_done,
  output logic       auto_trig,
  output logic [1:0] state
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam logic [9:0]    BASE     = 10'(BASE_ADDR);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(AUTO_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    dec_q, dec_d;
  logic [TW-1:0] to_q, to_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [9:0]    wr_addr_q, wr_addr_d;
  logic          wren_q, wren_d;
  logic          done_q, done_d;
  logic          auto_q, auto_d;

  logic          accept;
  logic          crossing;
  logic          do_wr;
  logic [IW-1:0] widx;

  assign accept   = sample_en && (dec_q == decim);
  assign crossing = prev_valid_q && (prev_q < trig_level) && (adc_data >= trig_level);

  always_comb begin
    state_d      = state_q;
    dec_d        = dec_q;
    to_d         = to_q;
    idx_d        = idx_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    wren_d       = 1'b0;
    done_d       = done_q;
    auto_d       = auto_q;
    do_wr        = 1'b0;
    widx         = idx_q;

    // 4-bit counter wraps naturally, so a shrinking decim can never push it past 15.
    if ((state_q == S_ARMED || state_q == S_CAPTURE) && sample_en) begin
      dec_d = accept ? 4'd0 : dec_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d      = S_ARMED;
          prev_valid_d = 1'b0;
          to_d         = '0;
        end
      end
      S_ARMED: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if (crossing || to_q == TO_LAST) begin
            auto_d = !crossing;
            do_wr  = 1'b1;
            widx   = '0;
          end else begin
            to_d         = to_q + TO_ONE;
            prev_d       = adc_data;
            prev_valid_d = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        // Abort wins over a same-cycle strobe: a partial frame is left as is.
        if (!run) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (accept) begin
          do_wr = 1'b1;
          widx  = idx_q;
        end
      end
      default: begin
        if (frame_ack) begin
          done_d = 1'b0;
          if (run) begin
            state_d      = S_ARMED;
            prev_valid_d = 1'b0;
            to_d         = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase

    if (do_wr) begin
      wren_d    = 1'b1;
      wr_data_d = adc_data;
      wr_addr_d = BASE + 10'(widx);
      if (widx == LAST_IDX) begin
        state_d = S_HOLD;
        done_d  = 1'b1;
        idx_d   = '0;
      end else begin
        state_d = S_CAPTURE;
        idx_d   = widx + IDX_ONE;
      end
    end

    if (state_d != state_q) begin
      dec_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dec_q        <= '0;
      to_q         <= '0;
      idx_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= BASE;
      wren_q       <= 1'b0;
      done_q       <= 1'b0;
      auto_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_q        <= dec_d;
      to_q         <= to_d;
      idx_q        <= idx_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      wren_q       <= wren_d;
      done_q       <= done_d;
      auto_q       <= auto_d;
    end
  end

  assign ram_wr_data = wr_data_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wren    = wren_q;
  assign frame_done  = done_q;
  assign auto_trig   = auto_q;
  assign state       = state_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture: directed frames with expected RAM writes queued
// up front and checked by an independent write monitor.
module tb_adc_frame_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       sample_en;
  logic [7:0] adc_data;
  logic [7:0] trig_level;
  logic [3:0] decim;
  logic       frame_ack;
  logic [7:0] ram_wr_data;
  logic [9:0] ram_wr_addr;
  logic       ram_wren;
  logic       frame_done;
  logic       auto_trig;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;
  // {frame_done, addr, data}
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  adc_frame_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .sample_en   (sample_en),
    .adc_data    (adc_data),
    .trig_level  (trig_level),
    .decim       (decim),
    .frame_ack   (frame_ack),
    .ram_wr_data (ram_wr_data),
    .ram_wr_addr (ram_wr_addr),
    .ram_wren    (ram_wren),
    .frame_done  (frame_done),
    .auto_trig   (auto_trig),
    .state       (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [18:0] got;
    logic [18:0] e;
    if (rst_n && ram_wren) begin
      got = {frame_done, ram_wr_addr, ram_wr_data};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        check("ram_write", got, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_en = 1'b0;
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    sample_en = 1'b1;
    adc_data  = v;
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) strobe(i[7:0]);
    idle(2);
  endtask

  task automatic push_frame(input int first, input int step, input int n, input bit full);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(full && i == 127), 10'(i), 8'(first + step * i)});
  endtask

  task automatic ack(input logic run_after, input logic [1:0] exp_state);
    @(negedge clk);
    sample_en = 1'b0;
    run       = run_after;
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check("ack_frame_done", frame_done, 0);
    check("ack_state", state, exp_state);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; sample_en = 1'b0; adc_data = 8'd0;
    trig_level = 8'd100; decim = 4'd0; frame_ack = 1'b0;
    #12;
    check("rst_state", state, 0);
    check("rst_addr", ram_wr_addr, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_done", frame_done, 0);
    check("rst_auto", auto_trig, 0);
    check("rst_data", ram_wr_data, 0);
    @(negedge clk) rst_n = 1'b1;

    // stray ack in IDLE does nothing
    frame_ack = 1'b1;
    @(negedge clk) frame_ack = 1'b0;
    check("idle_ack_state", state, 0);

    // ramp, trigger at 100, one full frame 100..227
    run = 1'b1;
    idle(2);
    check("armed_state", state, 1);
    push_frame(100, 1, 128, 1'b1);
    ramp(230);
    check("a_state", state, 3);
    check("a_done", frame_done, 1);
    check("a_auto", auto_trig, 0);
    check("a_last_addr", ram_wr_addr, 127);
    check("a_q_empty", exp_q.size(), 0);

    // ack with run=1, then second frame with decim=3: 103, 107, ...
    decim = 4'd3;
    ack(1'b1, 2'd1);
    push_frame(103, 4, 128, 1'b1);
    ramp(620);
    check("c_state", state, 3);
    check("c_auto", auto_trig, 0);
    check("c_q_empty", exp_q.size(), 0);
    ack(1'b0, 2'd0);

    // flat input, auto trigger on the 1024th accepted sample
    decim = 4'd0;
    trig_level = 8'd200;
    run = 1'b1;
    idle(2);
    push_frame(50, 0, 128, 1'b1);
    for (int i = 0; i < 1023; i++) strobe(8'd50);
    idle(1);
    check("b_pre_state", state, 1);
    check("b_pre_auto", auto_trig, 0);
    check("b_pre_q", exp_q.size(), 128);
    for (int i = 0; i < 128; i++) strobe(8'd50);
    idle(2);
    check("b_state", state, 3);
    check("b_auto", auto_trig, 1);
    check("b_q_empty", exp_q.size(), 0);
    ack(1'b0, 2'd0);
    check("b_auto_kept", auto_trig, 1);

    // abort after write index 40; same-cycle strobe must not be written
    trig_level = 8'd100;
    run = 1'b1;
    idle(2);
    push_frame(100, 1, 41, 1'b0);
    for (int i = 0; i <= 140; i++) strobe(i[7:0]);
    @(negedge clk);
    run = 1'b0; sample_en = 1'b1; adc_data = 8'd141;
    @(negedge clk);
    sample_en = 1'b0;
    check("abort_state", state, 0);
    check("abort_done", frame_done, 0);
    for (int i = 142; i < 150; i++) strobe(i[7:0]);
    idle(2);
    check("abort_q_empty", exp_q.size(), 0);
    check("abort_last_addr", ram_wr_addr, 40);

    // asynchronous reset while a write is on the bus
    run = 1'b1;
    idle(2);
    push_frame(100, 1, 10, 1'b0);
    for (int i = 0; i <= 109; i++) strobe(i[7:0]);
    @(negedge clk);
    #1;
    sample_en = 1'b0;
    check("pre_rst_wren", ram_wren, 1);
    rst_n = 1'b0;
    #1;
    check("async_wren", ram_wren, 0);
    check("async_state", state, 0);
    check("async_addr", ram_wr_addr, 0);
    check("async_data", ram_wr_data, 0);
    check("async_done", frame_done, 0);
    check("async_auto", auto_trig, 0);
    check("rst_q_empty", exp_q.size(), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    push_frame(100, 1, 128, 1'b1);
    ramp(230);
    check("r_state", state, 3);
    check("r_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
